// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the alu control sequencer
// ALU operation codes, decoded-instruction classes and sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational instruction-to-alu-op decoder
// Maps {aluop, funct3, funct7[5]} to an alu operation code and flags illegal encodings.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_e    op_o,
  output logic       illegal_o
);

  aluop_e aluop;
  assign aluop = aluop_e'(aluop_i);

  always_comb begin
    op_o      = OP_ADD;
    illegal_o = 1'b0;
    case (aluop)
      ALUOP_LDST:   op_o = OP_ADD;
      ALUOP_BRANCH: op_o = OP_SUB;
      default: begin
        case (funct3_i)
          3'b000:  op_o = (aluop == ALUOP_RTYPE && funct7b5_i) ? OP_SUB : OP_ADD;
          3'b001:  op_o = OP_SLL;
          3'b010:  op_o = OP_SLT;
          3'b011:  op_o = OP_SLTU;
          3'b100:  op_o = OP_XOR;
          3'b101:  op_o = funct7b5_i ? OP_SRA : OP_SRL;
          3'b110:  op_o = OP_OR;
          default: op_o = OP_AND;
        endcase
        // I-type only has a funct7 field on shifts; ADDI ignores the bit.
        if (aluop == ALUOP_RTYPE && funct7b5_i && funct3_i != 3'b000 && funct3_i != 3'b101)
          illegal_o = 1'b1;
        if (aluop == ALUOP_ITYPE && funct3_i == 3'b001 && funct7b5_i)
          illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// rtl/alu_ctrl_sequencer.sv - request/response sequencer driving the alu
// One request in flight: IDLE accepts, EXEC lets the alu settle, RESP holds the result until taken.
module alu_ctrl_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_aluop,
  input  logic [2:0]              req_funct3,
  input  logic                    req_funct7b5,
  input  logic [WIDTH-1:0]        req_a,
  input  logic [WIDTH-1:0]        req_b,
  output logic [3:0]              operation,
  output logic [WIDTH-1:0]        A,
  output logic [WIDTH-1:0]        B,
  input  logic signed [WIDTH-1:0] ALUResult,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WIDTH-1:0]        resp_result,
  output logic                    resp_error,
  output logic [CNT_W-1:0]        op_count
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]       state_q, state_d;
  logic [3:0]       operation_q, operation_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_error_q, resp_error_d;
  logic [CNT_W-1:0] count_q, count_d;

  alu_op_e dec_op;
  logic    dec_illegal;

  alu_op_decode u_decode (
    .aluop_i    (req_aluop),
    .funct3_i   (req_funct3),
    .funct7b5_i (req_funct7b5),
    .op_o       (dec_op),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    state_d       = state_q;
    operation_d   = operation_q;
    a_d           = a_q;
    b_d           = b_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_error_d  = resp_error_q;
    count_d       = count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Illegal requests skip the alu entirely so its inputs keep their last legal values.
          if (dec_illegal) begin
            state_d       = S_RESP;
            resp_valid_d  = 1'b1;
            resp_error_d  = 1'b1;
            resp_result_d = '0;
          end else begin
            state_d      = S_EXEC;
            operation_d  = dec_op;
            a_d          = req_a;
            b_d          = req_b;
            resp_error_d = 1'b0;
          end
        end
      end
      S_EXEC: begin
        state_d       = S_RESP;
        resp_result_d = ALUResult;
        resp_valid_d  = 1'b1;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          count_d      = count_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      operation_q   <= 4'b0000;
      a_q           <= '0;
      b_q           <= '0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_error_q  <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      operation_q   <= operation_d;
      a_q           <= a_d;
      b_q           <= b_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_error_q  <= resp_error_d;
      count_q       <= count_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign operation   = operation_q;
  assign A           = a_q;
  assign B           = b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_error  = resp_error_q;
  assign op_count    = count_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// tb/tb_alu_ctrl_sequencer.sv - scoreboard bench for alu_ctrl_sequencer with a behavioural alu
// Driver pushes expected responses on acceptance; a negedge monitor pops and compares.
module tb_alu_ctrl_sequencer;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [1:0]       req_aluop;
  logic [2:0]       req_funct3;
  logic             req_funct7b5;
  logic [WIDTH-1:0] req_a, req_b;
  logic [3:0]       operation;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH-1:0] ALUResult;
  logic             resp_valid, resp_ready, resp_error;
  logic [WIDTH-1:0] resp_result;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_ctrl_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5), .req_a(req_a), .req_b(req_b),
    .operation(operation), .A(A), .B(B), .ALUResult(ALUResult),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_error(resp_error), .op_count(op_count)
  );

  // Behavioural alu driven by the sequencer.
  always_comb begin
    case (operation)
      4'b0000: ALUResult = A & B;
      4'b0001: ALUResult = A | B;
      4'b0010: ALUResult = A + B;
      4'b0011: ALUResult = A ^ B;
      4'b0100: ALUResult = A << B[4:0];
      4'b0101: ALUResult = A >> B[4:0];
      4'b0110: ALUResult = A - B;
      4'b0111: ALUResult = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      4'b1000: ALUResult = $signed(A) >>> B[4:0];
      4'b1001: ALUResult = (A < B) ? 32'd1 : 32'd0;
      4'b1100: ALUResult = ~(A | B);
      default: ALUResult = '0;
    endcase
  end

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        err;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          model_cnt = 0;
  int          rr_mode = 0;
  logic [3:0]  last_op;
  logic [31:0] last_a, last_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Instruction semantics straight from the decode rules, independent of op encoding.
  function automatic void model(input logic [1:0] ao, input logic [2:0] f3, input logic f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic ill, output logic [3:0] code, output logic [31:0] res);
    ill = (ao == 2'b10 && f7 && f3 != 3'd0 && f3 != 3'd5) || (ao == 2'b11 && f3 == 3'd1 && f7);
    if (ao == 2'b00) begin code = 4'b0010; res = a + b; end
    else if (ao == 2'b01) begin code = 4'b0110; res = a - b; end
    else begin
      case (f3)
        3'd0: if (ao == 2'b10 && f7) begin code = 4'b0110; res = a - b; end
              else begin code = 4'b0010; res = a + b; end
        3'd1: begin code = 4'b0100; res = a << b[4:0]; end
        3'd2: begin code = 4'b0111; res = {31'd0, $signed(a) < $signed(b)}; end
        3'd3: begin code = 4'b1001; res = {31'd0, a < b}; end
        3'd4: begin code = 4'b0011; res = a ^ b; end
        3'd5: if (f7) begin code = 4'b1000; res = $signed(a) >>> b[4:0]; end
              else begin code = 4'b0101; res = a >> b[4:0]; end
        3'd6: begin code = 4'b0001; res = a | b; end
        default: begin code = 4'b0000; res = a & b; end
      endcase
    end
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [1:0] ao, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, input bit keep,
                      output int acc_cyc);
    bit acc = 0;
    int waited = 0;
    logic ill;
    logic [3:0] code;
    logic [31:0] res;
    exp_t e;
    req_valid = 1'b1; req_aluop = ao; req_funct3 = f3; req_funct7b5 = f7; req_a = a; req_b = b;
    acc_cyc = -1;
    while (!acc && waited < 50) begin
      @(negedge clk); #1;
      if (req_ready) begin
        acc = 1;
        acc_cyc = cyc;
        model(ao, f3, f7, a, b, ill, code, res);
        e.due = cyc + (ill ? 1 : 2);
        e.err = ill;
        e.res = ill ? 32'd0 : res;
        e.op  = ill ? last_op : code;
        e.a   = ill ? last_a : a;
        e.b   = ill ? last_b : b;
        if (!ill) begin last_op = code; last_a = a; last_b = b; end
        sb.push_back(e);
      end
      @(posedge clk); #1;
      waited++;
    end
    if (!keep) req_valid = 1'b0;
    if (!acc) fail_now("accept_timeout");
  endtask

  task automatic rand_req(input bit legal_only, output logic [1:0] ao, output logic [2:0] f3,
                          output logic f7);
    logic ill;
    logic [3:0] code;
    logic [31:0] res;
    do begin
      ao = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      model(ao, f3, f7, 32'd0, 32'd0, ill, code, res);
    end while (legal_only && ill);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: resp_ready = 1'b1;
        1: resp_ready = ($urandom_range(0, 3) != 0);
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  initial begin
    bit seen = 0;
    logic [31:0] s_res;
    logic s_err;
    forever begin
      @(negedge clk);
      if (reset) begin seen = 0; continue; end
      chk("req_ready", {31'd0, req_ready}, {31'd0, sb.size() == 0});
      chk("op_count", {16'd0, op_count}, {16'd0, CNT_W'(model_cnt)});
      if (resp_valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          if (!seen) begin
            seen = 1; s_res = resp_result; s_err = resp_error;
            chk("resp_latency", cyc, sb[0].due);
            chk("operation", {28'd0, operation}, {28'd0, sb[0].op});
            chk("alu_A", A, sb[0].a);
            chk("alu_B", B, sb[0].b);
          end else begin
            chk("hold_result", resp_result, s_res);
            chk("hold_error", {31'd0, resp_error}, {31'd0, s_err});
          end
          if (resp_ready) begin
            chk("resp_result", resp_result, sb[0].res);
            chk("resp_error", {31'd0, resp_error}, {31'd0, sb[0].err});
            void'(sb.pop_front());
            model_cnt++;
            seen = 0;
          end
        end
      end else if (seen) begin
        fail_now("resp_valid_dropped");
        seen = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev, waited;
    logic [1:0] ao;
    logic [2:0] f3;
    logic f7;
    logic [CNT_W-1:0] saved_cnt;
    logic [31:0] saved_res;

    reset = 1'b1; req_valid = 1'b0; req_aluop = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
    req_a = '0; req_b = '0; resp_ready = 1'b1;
    last_op = '0; last_a = '0; last_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_operation", {28'd0, operation}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;

    // Directed: load/store add, sub, slt, sltu, illegal
    send(2'b00, 3'd0, 1'b0, 32'd197, -32'sd237, 0, acc);
    repeat (3) @(posedge clk); #1;
    send(2'b10, 3'd0, 1'b1, 32'd197, -32'sd237, 0, acc);
    repeat (3) @(posedge clk); #1;
    send(2'b10, 3'd2, 1'b0, 32'd197, -32'sd237, 0, acc);
    repeat (3) @(posedge clk); #1;
    send(2'b10, 3'd3, 1'b0, 32'd197, -32'sd237, 0, acc);
    repeat (3) @(posedge clk); #1;
    send(2'b10, 3'd4, 1'b1, 32'd197, -32'sd237, 0, acc);
    repeat (3) @(posedge clk); #1;
    send(2'b11, 3'd0, 1'b1, 32'd5, 32'd7, 0, acc);
    repeat (3) @(posedge clk); #1;
    send(2'b11, 3'd1, 1'b1, 32'd5, 32'd7, 0, acc);
    repeat (3) @(posedge clk); #1;

    // Back-pressure hold
    rr_mode = 2;
    @(posedge clk); #1;
    send(2'b10, 3'd5, 1'b1, 32'h8000_00f0, 32'd4, 0, acc);
    waited = 0;
    while (!resp_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    if (!resp_valid) fail_now("hold_no_response");
    saved_cnt = op_count;
    saved_res = resp_result;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_res", resp_result, saved_res);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_count", {16'd0, op_count}, {16'd0, saved_cnt});
    end
    rr_mode = 0;
    repeat (4) @(posedge clk); #1;
    chk("hold_count_inc", {16'd0, op_count}, {16'd0, saved_cnt + CNT_W'(1)});

    // Reset during EXEC
    send(2'b10, 3'd6, 1'b0, 32'h1234, 32'h00f0, 0, acc);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rexec_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rexec_operation", {28'd0, operation}, 32'd0);
    chk("rexec_op_count", {16'd0, op_count}, 32'd0);
    chk("rexec_req_ready", {31'd0, req_ready}, 32'd1);
    sb.delete();
    model_cnt = 0;
    last_op = '0; last_a = '0; last_b = '0;
    reset = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Back-to-back legal requests with req_valid held high
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      rand_req(1, ao, f3, f7);
      send(ao, f3, f7, $urandom, $urandom, (i != 5), acc);
      if (prev >= 0) chk("b2b_spacing", acc - prev, 32'd3);
      prev = acc;
    end

    // Randomized traffic with random back-pressure, illegal encodings included
    rr_mode = 1;
    for (int i = 0; i < 200; i++) begin
      rand_req(0, ao, f3, f7);
      send(ao, f3, f7, $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom, 0, acc);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    rr_mode = 0;
    waited = 0;
    while ((sb.size() != 0 || resp_valid) && waited < 100) begin @(posedge clk); #1; waited++; end
    if (sb.size() != 0 || resp_valid) fail_now("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
